rename_queue: RTL and testbench

FIFO buffer between the ID stage and the Rename stage of the out-of-order pipeline. It accepts one decoded instruction bundle per cycle from ID and presents the oldest bundle to Rename in first-word-fall-through (FWFT) form. It supplies the back-pressure signal ID samples before enqueueing. Full is raised early so that ID's registered, one-cycle-late enqueue never overflows the queue.

---
 rtl/rename_queue.sv | 129 ++++++++++++
 tb/tb_rename_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_queue.sv
// ----------------------------------------------------------------------------
// rename_queue
//
// FIFO between the ID stage and the Rename stage. ID pushes one decoded
// bundle per cycle. Rename always sees the oldest bundle on RNMQ_DATA_OUT in
// first-word-fall-through form.
//
// Handshake semantics:
//   Enqueue side: ID samples RNMQ_full one cycle before it asserts RNMQ_NQ.
//     For that reason RNMQ_full rises SKID entries early. An RNMQ_NQ is
//     accepted whenever real capacity remains (count < DEPTH), whatever
//     the state of RNMQ_full. An enqueue at count == DEPTH is dropped and
//     sets the sticky RNMQ_overflow flag.
//   Dequeue side: RNMQ_empty is the inverse of "valid". An RNMQ_DQ pops the
//     head only when the queue is non-empty. A DQ on an empty queue has no
//     effect.
//   FLUSH empties the queue and masks any NQ/DQ in the same cycle.
//   RESET outranks everything.
//
// Ports:
//   CLK, RESET (sync, active-high), FLUSH
//   RNMQ_NQ, RNMQ_DATA_IN       : enqueue strobe and payload from ID
//   RNMQ_full                   : early back-pressure to ID
//   RNMQ_DQ                     : dequeue strobe from Rename
//   RNMQ_DATA_OUT               : head bundle, or zero when empty
//   RNMQ_empty, RNMQ_count      : occupancy status
//   RNMQ_overflow               : sticky dropped-enqueue flag
// ----------------------------------------------------------------------------
module rename_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 134,
  parameter int SKID   = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     RNMQ_NQ,
  input  logic [DATA_W-1:0]        RNMQ_DATA_IN,
  output logic                     RNMQ_full,
  input  logic                     RNMQ_DQ,
  output logic [DATA_W-1:0]        RNMQ_DATA_OUT,
  output logic                     RNMQ_empty,
  output logic [$clog2(DEPTH):0]   RNMQ_count,
  output logic                     RNMQ_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(DEPTH - SKID);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic enq_ok;
  logic deq_ok;
  logic mem_we;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    // Acceptance uses true capacity, not RNMQ_full. The SKID slots exist
    // only to absorb ID's one-cycle-late enqueue.
    enq_ok = RNMQ_NQ && (count_q < DEPTH_C);
    deq_ok = RNMQ_DQ && (count_q != '0);

    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (RNMQ_NQ && (count_q == DEPTH_C)) begin
        overflow_d = 1'b1;
      end
      if (enq_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({enq_ok, deq_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The storage array has no reset. Stale contents are harmless because
  // DATA_OUT is forced to zero whenever count is zero.
  always_ff @(posedge CLK) begin
    if (!RESET && mem_we) begin
      mem_q[wr_ptr_q] <= RNMQ_DATA_IN;
    end
  end

  always_comb begin
    RNMQ_empty    = (count_q == '0);
    RNMQ_full     = (count_q >= FULL_THR);
    RNMQ_count    = count_q;
    RNMQ_overflow = overflow_q;
    RNMQ_DATA_OUT = RNMQ_empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_rename_queue.sv
module tb_rename_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 134;
  localparam int SKID   = 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              nq;
  logic              dq;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  always #5 clk = ~clk;

  rename_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SKID(SKID)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .FLUSH         (flush),
    .RNMQ_NQ       (nq),
    .RNMQ_DATA_IN  (din),
    .RNMQ_full     (full),
    .RNMQ_DQ       (dq),
    .RNMQ_DATA_OUT (dout),
    .RNMQ_empty    (empty),
    .RNMQ_count    (count),
    .RNMQ_overflow (overflow)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Build a bundle whose fields all derive from the Instr word.
  function automatic logic [DATA_W-1:0] bundle(input logic [31:0] instr);
    logic [31:0] pc;
    pc = instr ^ 32'h0000_1000;
    return {instr, pc, pc + 32'd4, instr[4:0], instr[9:5], instr[14:10],
            instr[15], instr[21:16], instr[22], instr[23], instr[28:24],
            instr[8:0]};
  endfunction

  // ---------------- reference model ----------------
  // The reference keeps the queue contents as a plain SV queue. It applies
  // the accept, drop, flush and reset rules directly to that queue.
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf   = 1'b0;
  logic              m_valid = 1'b0;

  always @(posedge clk) begin
    int  sz;
    logic do_enq;
    logic do_deq;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      do_enq = nq && (sz < DEPTH);
      do_deq = dq && (sz != 0);
      if (nq && sz == DEPTH) m_ovf = 1'b1;
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) exp_q.push_back(din);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      int sz;
      sz = exp_q.size();
      check("cyc_count", DATA_W'(count), DATA_W'(sz));
      check("cyc_empty", DATA_W'(empty), DATA_W'(sz == 0));
      check("cyc_full", DATA_W'(full), DATA_W'(sz >= DEPTH - SKID));
      check("cyc_overflow", DATA_W'(overflow), DATA_W'(m_ovf));
      check("cyc_data", dout, (sz != 0) ? exp_q[0] : '0);
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic f, input logic n,
                       input logic d, input logic [31:0] instr);
    rst   = r;
    flush = f;
    nq    = n;
    dq    = d;
    din   = bundle(instr);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] instr_of(input logic [DATA_W-1:0] b);
    return DATA_W'(b[DATA_W-1 -: 32]);
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; nq = 1'b0; dq = 1'b0; din = '0;
    cycle(1, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    check("rst_empty", DATA_W'(empty), DATA_W'(1));
    check("rst_count", DATA_W'(count), DATA_W'(0));
    check("rst_full", DATA_W'(full), DATA_W'(0));
    check("rst_data", dout, '0);

    // Three bundles, no dequeue.
    cycle(0, 0, 1, 0, 32'h2001_0001);
    cycle(0, 0, 1, 0, 32'h2002_0002);
    cycle(0, 0, 1, 0, 32'h2003_0003);
    check("enq3_count", DATA_W'(count), DATA_W'(3));
    check("enq3_empty", DATA_W'(empty), DATA_W'(0));
    check("enq3_full", DATA_W'(full), DATA_W'(0));
    check("enq3_instr", instr_of(dout), DATA_W'(32'h2001_0001));
    check("enq3_bundle", dout, bundle(32'h2001_0001));

    // Fill up. Full must rise at 7, not before.
    for (int i = 4; i <= 7; i++) begin
      cycle(0, 0, 1, 0, 32'h2000_0000 + 32'(i));
      if (i == 6) check("fill6_full", DATA_W'(full), DATA_W'(0));
    end
    check("fill7_count", DATA_W'(count), DATA_W'(7));
    check("fill7_full", DATA_W'(full), DATA_W'(1));
    cycle(0, 0, 1, 0, 32'h2000_0008);
    check("fill8_count", DATA_W'(count), DATA_W'(8));
    check("fill8_ovf", DATA_W'(overflow), DATA_W'(0));
    cycle(0, 0, 1, 0, 32'h2000_0009);
    check("drop_count", DATA_W'(count), DATA_W'(8));
    check("drop_ovf", DATA_W'(overflow), DATA_W'(1));
    check("drop_head", instr_of(dout), DATA_W'(32'h2001_0001));

    // Steady enqueue+dequeue at count 2. The pointers wrap several times.
    cycle(1, 0, 0, 0, 32'h0);
    cycle(0, 0, 1, 0, 32'h3000_0000);
    cycle(0, 0, 1, 0, 32'h3000_0001);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 1, 1, 32'h4000_0000 + 32'(k));
      if (k == 9) check("steady_count_mid", DATA_W'(count), DATA_W'(2));
    end
    check("steady_count", DATA_W'(count), DATA_W'(2));
    check("steady_head", instr_of(dout), DATA_W'(32'h4000_0012));

    // Flush with simultaneous NQ and DQ while holding 5 entries.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'h5000_0000 + 32'(i));
    check("pre_flush_count", DATA_W'(count), DATA_W'(5));
    cycle(0, 1, 1, 1, 32'h5555_5555);
    check("flush_count", DATA_W'(count), DATA_W'(0));
    check("flush_empty", DATA_W'(empty), DATA_W'(1));
    check("flush_data", dout, '0);
    cycle(0, 0, 1, 0, 32'hDEAD_BEEF);
    check("post_flush_instr", instr_of(dout), DATA_W'(32'hDEAD_BEEF));
    check("post_flush_count", DATA_W'(count), DATA_W'(1));

    // Underflow is ignored. NQ+DQ on empty leaves one entry.
    cycle(0, 1, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    check("uflow_count", DATA_W'(count), DATA_W'(0));
    check("uflow_ovf", DATA_W'(overflow), DATA_W'(0));
    check("uflow_empty", DATA_W'(empty), DATA_W'(1));
    cycle(0, 0, 1, 1, 32'h6000_0001);
    check("nqdq_empty_count", DATA_W'(count), DATA_W'(1));
    check("nqdq_empty_instr", instr_of(dout), DATA_W'(32'h6000_0001));
    cycle(0, 0, 0, 1, 32'h0);

    // Overflow, drain to 6, then reset during an enqueue.
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 32'h7000_0000 + 32'(i));
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h0);
    check("pre_rst_count", DATA_W'(count), DATA_W'(6));
    check("pre_rst_ovf", DATA_W'(overflow), DATA_W'(1));
    check("pre_rst_head", instr_of(dout), DATA_W'(32'h7000_0002));
    cycle(1, 0, 1, 0, 32'h7777_7777);
    check("rst2_count", DATA_W'(count), DATA_W'(0));
    check("rst2_empty", DATA_W'(empty), DATA_W'(1));
    check("rst2_ovf", DATA_W'(overflow), DATA_W'(0));
    check("rst2_data", dout, '0);
    cycle(0, 0, 0, 0, 32'h0);
    check("rst2_idle_count", DATA_W'(count), DATA_W'(0));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
